// File: rtl/mac_tile_dual.sv
// mac_tile_dual: dual-mode systolic MAC tile (WS: weight held, psum flows south; OS: accumulator held, weights flow south)
// Ports: clk/reset (sync, active-high); os_mode selects WS/OS when idle; in_w/out_e carry activations east;
// inst_w/inst_e carry {drain-or-clear, execute, load} east; in_n/out_s carry psum, weight or drained accumulator south.
module mac_tile_dual #(
  parameter int bw = 4,
  parameter int psum_bw = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               os_mode,
  input  logic [bw-1:0]      in_w,
  input  logic [2:0]         inst_w,
  input  logic [psum_bw-1:0] in_n,
  output logic [bw-1:0]      out_e,
  output logic [2:0]         inst_e,
  output logic [psum_bw-1:0] out_s
);
  logic [bw-1:0]      r_a;
  logic [bw-1:0]      r_b;
  logic [psum_bw-1:0] r_c;
  logic [psum_bw-1:0] r_acc;
  logic [2:0]         r_inst;
  logic               r_load_ready;
  logic               r_mode;
  logic               r_vld;
  logic [psum_bw-1:0] w_prod;
  // unsigned activation times signed weight, taken modulo 2^psum_bw
  assign w_prod = psum_bw'(r_a) * psum_bw'($signed(r_b));
  assign out_e  = r_a;
  assign inst_e = r_inst;
  assign out_s  = r_mode ? (r_inst[2] ? r_acc : psum_bw'(r_b)) : w_prod + r_c;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a          <= '0;
      r_b          <= '0;
      r_c          <= '0;
      r_acc        <= '0;
      r_inst       <= '0;
      r_load_ready <= 1'b1;
      r_mode       <= 1'b0;
      r_vld        <= 1'b0;
    end else begin
      if (inst_w == 3'b000 && !r_vld) r_mode <= os_mode;
      if (inst_w[0] | inst_w[1]) r_a <= in_w;
      r_inst[2:1] <= inst_w[2:1];
      if (!r_mode) begin
        r_c <= in_n;
        // the first load token after a clear is consumed here; later ones travel east
        r_inst[0] <= inst_w[0] & ~inst_w[2] & ~r_load_ready;
        if (inst_w[2]) r_load_ready <= 1'b1;
        else if (inst_w[0] && r_load_ready) begin
          r_b          <= in_w;
          r_load_ready <= 1'b0;
        end
      end else begin
        r_inst[0] <= 1'b0;
        r_vld     <= inst_w[1] & ~inst_w[2];
        if (inst_w[1] && !inst_w[2]) r_b <= in_n[bw-1:0];
        // first drain cycle exposes the tile's own accumulator; later drain cycles shift the column down
        if (inst_w[2]) begin
          if (r_inst[2]) r_acc <= in_n;
        end else if (r_vld) r_acc <= r_acc + w_prod;
      end
    end
  end
endmodule

// File: tb/tb_mac_tile_dual.sv
// tb_mac_tile_dual: directed plus randomized checks of a 3-tile column of mac_tile_dual
module tb_mac_tile_dual;
  logic        clk = 1'b0;
  logic        reset;
  logic        os_mode;
  logic [2:0]  inst_w;
  logic [3:0]  in_w0, in_w1, in_w2;
  logic [15:0] in_n;
  logic [3:0]  out_e0, out_e1, out_e2;
  logic [2:0]  inst_e0, inst_e1, inst_e2;
  logic [15:0] out_s0, out_s1, out_s2;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  mac_tile_dual #(.bw(4), .psum_bw(16)) t0 (
    .clk(clk), .reset(reset), .os_mode(os_mode), .in_w(in_w0), .inst_w(inst_w), .in_n(in_n),
    .out_e(out_e0), .inst_e(inst_e0), .out_s(out_s0));
  mac_tile_dual #(.bw(4), .psum_bw(16)) t1 (
    .clk(clk), .reset(reset), .os_mode(os_mode), .in_w(in_w1), .inst_w(inst_w), .in_n(out_s0),
    .out_e(out_e1), .inst_e(inst_e1), .out_s(out_s1));
  mac_tile_dual #(.bw(4), .psum_bw(16)) t2 (
    .clk(clk), .reset(reset), .os_mode(os_mode), .in_w(in_w2), .inst_w(inst_w), .in_n(out_s1),
    .out_e(out_e2), .inst_e(inst_e2), .out_s(out_s2));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic restart(input logic mode);
    reset = 1'b1;
    os_mode = mode;
    inst_w = 3'b000;
    in_w0 = 0; in_w1 = 0; in_w2 = 0; in_n = 0;
    step();
    reset = 1'b0;
    step();
  endtask
  function automatic logic [15:0] mac(input int a, input logic [3:0] w, input int c);
    int p;
    p = a * int'($signed(w)) + c;
    return 16'(p);
  endfunction
  initial begin
    int acc;
    int n;
    logic [3:0] w, a, b;
    logic [15:0] c;
    restart(1'b0);
    chk("reset_out_e", 16'(out_e0), 16'h0);
    chk("reset_inst_e", 16'(inst_e0), 16'h0);
    chk("reset_out_s", out_s0, 16'h0);
    // WS load / execute
    inst_w = 3'b001; in_w0 = 4'd3; step();
    chk("ws_first_token", 16'(inst_e0[0]), 16'h0);
    inst_w = 3'b001; in_w0 = 4'd5; step();
    chk("ws_second_token", 16'(inst_e0[0]), 16'h1);
    inst_w = 3'b010; in_w0 = 4'd2; in_n = 16'd10; step();
    chk("ws_exec_out_s", out_s0, mac(2, 4'd3, 10));
    chk("ws_exec_out_e", 16'(out_e0), 16'd2);
    chk("ws_exec_inst_e", 16'(inst_e0), 16'b010);
    // WS signed wrap
    inst_w = 3'b100; step();
    inst_w = 3'b001; in_w0 = 4'b1000; step();
    inst_w = 3'b010; in_w0 = 4'd15; in_n = 16'h0000; step();
    chk("ws_neg_wrap", out_s0, 16'hFF88);
    inst_w = 3'b100; step();
    inst_w = 3'b001; in_w0 = 4'd7; step();
    inst_w = 3'b010; in_w0 = 4'd1; in_n = 16'h7FFF; step();
    chk("ws_pos_wrap", out_s0, 16'h8006);
    // WS reload without reset, and clear beating load
    inst_w = 3'b100; step();
    inst_w = 3'b001; in_w0 = 4'd3; step();
    inst_w = 3'b100; step();
    inst_w = 3'b001; in_w0 = 4'd6; step();
    inst_w = 3'b010; in_w0 = 4'd1; in_n = 16'd0; step();
    chk("ws_reload", out_s0, 16'd6);
    inst_w = 3'b101; in_w0 = 4'd9; step();
    inst_w = 3'b010; in_w0 = 4'd1; step();
    chk("ws_clear_beats_load", out_s0, 16'd6);
    inst_w = 3'b001; in_w0 = 4'd2; step();
    inst_w = 3'b010; in_w0 = 4'd1; step();
    chk("ws_load_after_clear", out_s0, 16'd2);
    // WS randomized
    for (int i = 0; i < 8; i++) begin
      w = 4'($urandom_range(0, 15));
      a = 4'($urandom_range(0, 15));
      c = 16'($urandom_range(0, 65535));
      inst_w = 3'b100; step();
      inst_w = 3'b001; in_w0 = w; step();
      inst_w = 3'b010; in_w0 = a; in_n = c; step();
      chk("ws_random", out_s0, mac(int'(a), w, int'(c)));
    end
    // OS accumulate and drain
    restart(1'b1);
    for (int i = 1; i <= 4; i++) begin
      inst_w = 3'b010; in_w0 = 4'(i); in_n = 16'd2; step();
    end
    inst_w = 3'b000; step();
    chk("os_idle_out_s_is_weight", out_s0, 16'd2);
    inst_w = 3'b100; in_n = 16'd7; step();
    chk("os_drain_own", out_s0, 16'd20);
    step();
    chk("os_drain_from_north", out_s0, 16'd7);
    // OS randomized
    for (int k = 0; k < 3; k++) begin
      restart(1'b1);
      acc = 0;
      n = $urandom_range(2, 6);
      for (int i = 0; i < n; i++) begin
        a = 4'($urandom_range(0, 15));
        b = 4'($urandom_range(0, 15));
        acc += int'(a) * int'($signed(b));
        inst_w = 3'b010; in_w0 = a; in_n = {12'h0, b}; step();
      end
      inst_w = 3'b000; in_n = 16'd0; step();
      chk("os_random_weight", out_s0, {12'h0, b});
      inst_w = 3'b100; step();
      chk("os_random_acc", out_s0, 16'(acc));
    end
    // OS 3-tile column drain
    restart(1'b1);
    for (int i = 0; i < 3; i++) begin
      inst_w = 3'b010; in_n = 16'd1; step();
    end
    in_w0 = 4'd5; in_w1 = 4'd9; in_w2 = 4'd11; step();
    inst_w = 3'b000; in_n = 16'd0; step();
    inst_w = 3'b100; step();
    chk("col_drain_0", out_s2, 16'd11);
    step();
    chk("col_drain_1", out_s2, 16'd9);
    step();
    chk("col_drain_2", out_s2, 16'd5);
    step();
    chk("col_empty_t0", out_s0, 16'd0);
    chk("col_empty_t1", out_s1, 16'd0);
    chk("col_empty_t2", out_s2, 16'd0);
    // mode lock during execute, then reset mid-accumulate
    inst_w = 3'b000; step();
    inst_w = 3'b010; in_w0 = 4'd3; in_n = 16'd2; os_mode = 1'b0;
    step(); step(); step();
    chk("mode_lock", 16'(t0.r_mode), 16'h1);
    chk("mid_acc_nonzero", 16'(t0.r_acc != 16'd0), 16'h1);
    reset = 1'b1; step();
    reset = 1'b0;
    chk("reset_acc", t0.r_acc, 16'h0);
    chk("reset_load_ready", 16'(t0.r_load_ready), 16'h1);
    chk("reset_mid_out_s", out_s0, 16'h0);
    chk("reset_mid_out_e", 16'(out_e0), 16'h0);
    chk("reset_mid_inst_e", 16'(inst_e0), 16'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
